pix_dot_mac_pipe: RTL and testbench

- Parametrised, pipelined N-channel dot-product unit: out = sat(round((Σ a_i·b_i) >> SHIFT) + offset).
- Operands: unsigned pixel components a_i, signed coefficients b_i.
- Successor to the fixed 16u×8s 4-stage multiplier. Adds channel count, rounding/shift, offset, unsigned saturation with flag, and valid/ready backpressure.
- Used in the test-pattern / colour-conversion path, between the pixel generator and the output stream.

---
 rtl/pix_dot_mac_pipe.sv | 171 +++++++++++++++++
 tb/tb_pix_dot_mac_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_dot_mac_pipe.sv
// Pipelined N-channel dot product: out = sat(round((sum a_i*b_i) >> SHIFT) + offset).
// Four register stages behind a single pipeline enable; unsigned saturation with overflow flag.
module pix_dot_mac_pipe #(
  parameter int NUM_CH = 3,
  parameter int A_W    = 16,
  parameter int B_W    = 8,
  parameter int SHIFT  = 7,
  parameter int OUT_W  = 16,
  parameter int OFF_W  = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*A_W-1:0]   a_data,
  input  logic [NUM_CH*B_W-1:0]   b_coef,
  input  logic signed [OFF_W-1:0] offset,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_ovf
);

  // Product of a zero-extended unsigned A_W value and a signed B_W value fits A_W+B_W signed bits.
  // One extra sum bit absorbs the rounding constant on top of NUM_CH worst-case products.
  localparam int P_W     = A_W + B_W;
  localparam int S_W     = P_W + $clog2(NUM_CH) + 1;
  localparam int V_W     = ((S_W > OFF_W) ? S_W : OFF_W) + 1;
  localparam int X_W     = (V_W > OUT_W + 1) ? V_W : OUT_W + 2;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [S_W-1:0] RND     = (SHIFT > 0) ? (S_W'(1) << RND_POS) : '0;
  localparam logic [X_W-2:0]        OUT_MAX = {{(X_W-1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic en;
  logic run_reg;

  logic [NUM_CH*A_W-1:0]   a_s1_reg;
  logic [NUM_CH*B_W-1:0]   b_s1_reg;
  logic signed [OFF_W-1:0] off_s1_reg;
  logic                    vld_s1_reg;

  logic signed [P_W-1:0]   prod_next [NUM_CH];
  logic signed [P_W-1:0]   prod_s2_reg [NUM_CH];
  logic signed [OFF_W-1:0] off_s2_reg;
  logic                    vld_s2_reg;

  logic signed [S_W-1:0]   sum_next;
  logic signed [S_W-1:0]   sum_s3_reg;
  logic signed [OFF_W-1:0] off_s3_reg;
  logic                    vld_s3_reg;

  logic signed [S_W-1:0]   shifted;
  logic [X_W-1:0]          val_next;
  logic [OUT_W-1:0]        data_next;
  logic                    ovf_next;

  logic [OUT_W-1:0]        out_data_reg;
  logic                    out_ovf_reg;
  logic                    out_valid_reg;

  // Whole pipeline advances together; it only stalls when the output register is full and blocked.
  assign en        = out_ready | ~out_valid_reg;
  assign in_ready  = en & run_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // S1: operand capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_s1_reg   <= '0;
      b_s1_reg   <= '0;
      off_s1_reg <= '0;
      vld_s1_reg <= 1'b0;
    end else if (en) begin
      a_s1_reg   <= a_data;
      b_s1_reg   <= b_coef;
      off_s1_reg <= offset;
      vld_s1_reg <= in_valid & in_ready;
    end
  end

  // S2: per-channel exact signed products
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_mul
      logic signed [P_W-1:0] a_ext;
      logic signed [P_W-1:0] b_ext;
      assign a_ext         = {{B_W{1'b0}}, a_s1_reg[gi*A_W +: A_W]};
      assign b_ext         = {{A_W{b_s1_reg[gi*B_W+B_W-1]}}, b_s1_reg[gi*B_W +: B_W]};
      assign prod_next[gi] = a_ext * b_ext;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prod_s2_reg[i] <= '0;
      end
      off_s2_reg <= '0;
      vld_s2_reg <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prod_s2_reg[i] <= prod_next[i];
      end
      off_s2_reg <= off_s1_reg;
      vld_s2_reg <= vld_s1_reg;
    end
  end

  // S3: exact sum plus half-LSB so the later floor shift rounds half-up
  always_comb begin
    sum_next = RND;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_next = sum_next + {{(S_W-P_W){prod_s2_reg[i][P_W-1]}}, prod_s2_reg[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_s3_reg <= '0;
      off_s3_reg <= '0;
      vld_s3_reg <= 1'b0;
    end else if (en) begin
      sum_s3_reg <= sum_next;
      off_s3_reg <= off_s2_reg;
      vld_s3_reg <= vld_s2_reg;
    end
  end

  // S4: floor shift, offset, clamp to [0, 2^OUT_W-1]
  always_comb begin
    shifted   = sum_s3_reg >>> SHIFT;
    val_next  = {{(X_W-S_W){shifted[S_W-1]}}, shifted}
              + {{(X_W-OFF_W){off_s3_reg[OFF_W-1]}}, off_s3_reg};
    data_next = val_next[OUT_W-1:0];
    ovf_next  = 1'b0;
    if (val_next[X_W-1]) begin
      data_next = '0;
      ovf_next  = 1'b1;
    end else if (val_next[X_W-2:0] > OUT_MAX) begin
      data_next = '1;
      ovf_next  = 1'b1;
    end
  end

  // Result registers only load on a real beat so the last value survives bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (en) begin
      out_valid_reg <= vld_s3_reg;
      if (vld_s3_reg) begin
        out_data_reg <= data_next;
        out_ovf_reg  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_pix_dot_mac_pipe.sv
// Scoreboard bench for pix_dot_mac_pipe: expected beats are queued at accept and
// compared in order when the DUT hands a beat downstream.
module tb_pix_dot_mac_pipe;
  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int BW  = 8;
  localparam int SH  = 7;
  localparam int OW  = 16;
  localparam int FW  = 17;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NCH*AW-1:0]    a_data = '0;
  logic [NCH*BW-1:0]    b_coef = '0;
  logic signed [FW-1:0] offset = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [OW-1:0]        out_data;
  logic                 out_ovf;

  logic [OW:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  pix_dot_mac_pipe #(
    .NUM_CH(NCH), .A_W(AW), .B_W(BW), .SHIFT(SH), .OUT_W(OW), .OFF_W(FW)
  ) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_coef(b_coef), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [NCH*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {a2[AW-1:0], a1[AW-1:0], a0[AW-1:0]};
  endfunction

  function automatic logic [NCH*BW-1:0] pb(input int b0, input int b1, input int b2);
    return {b2[BW-1:0], b1[BW-1:0], b0[BW-1:0]};
  endfunction

  // Reference: returns {ovf, data}
  function automatic logic [OW:0] model(input logic [NCH*AW-1:0] a, input logic [NCH*BW-1:0] b,
                                        input logic signed [FW-1:0] o);
    longint s;
    logic [OW-1:0] d;
    s = 0;
    for (int i = 0; i < NCH; i++) begin
      s += longint'(a[i*AW +: AW]) * longint'($signed(b[i*BW +: BW]));
    end
    s += longint'(64);
    s = s >>> SH;
    s += longint'(o);
    if (s < 0) return {1'b1, {OW{1'b0}}};
    if (s > 65535) return {1'b1, {OW{1'b1}}};
    d = s[OW-1:0];
    return {1'b0, d};
  endfunction

  task automatic step(input logic v, input logic [NCH*AW-1:0] a, input logic [NCH*BW-1:0] b,
                      input logic signed [FW-1:0] o, input logic r, output logic acc, output logic cons);
    @(negedge clk);
    in_valid  = v;
    a_data    = a;
    b_coef    = b;
    offset    = o;
    out_ready = r;
    #1;
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL rst_data got=%0d want=0", out_data); end
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", out_ovf); end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    $display("reset released");
  endtask

  task automatic test_basic();
    logic acc, cons;
    logic [OW:0] e;
    int lat;
    lat = 0;
    step(1'b1, pa(100, 200, 300), pb(64, 32, 16), 0, 1'b1, acc, cons);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b want=1", acc); end
    if (acc) exp_q.push_back({1'b0, 16'd138});
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      step(1'b0, '0, '0, 0, 1'b1, acc, cons);
      if (cons) begin
        lat = c;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL basic_extra got=%0d want=none", out_data); end
        else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_data} !== e) begin
            bad++; $display("FAIL basic_data got=%0d/%0d want=%0d/%0d", out_data, out_ovf, e[OW-1:0], e[OW]);
          end
        end
        $display("beat basic data=%0d ovf=%0d", out_data, out_ovf);
      end
    end
    total++;
    if (lat != 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
  endtask

  task automatic test_saturation();
    int ta0[8] = '{1000, 100, 100, 65535, 1999, 0, 0, 1999};
    int ta1[8] = '{0, 200, 200, 65535, 0, 0, 0, 0};
    int ta2[8] = '{0, 300, 300, 65535, 0, 0, 0, 0};
    int tb0[8] = '{-128, 64, 64, 127, -64, 0, 0, -64};
    int tb1[8] = '{0, 32, 32, 127, 0, 0, 0, 0};
    int tb2[8] = '{0, 16, 16, 127, 0, 0, 0, 0};
    int tof[8] = '{0, -200, 100, 0, 1000, 65535, -1, 999};
    int tdt[8] = '{0, 0, 238, 65535, 1, 65535, 0, 0};
    int tov[8] = '{1, 1, 0, 1, 0, 0, 1, 0};
    logic acc, cons;
    logic [OW:0] e;
    logic [OW-1:0] d;
    int idx, n_out;
    idx = 0;
    n_out = 0;
    for (int c = 0; c < 40 && n_out < 8; c++) begin
      if (idx < 8) step(1'b1, pa(ta0[idx], ta1[idx], ta2[idx]), pb(tb0[idx], tb1[idx], tb2[idx]),
                        FW'(tof[idx]), 1'b1, acc, cons);
      else step(1'b0, '0, '0, 0, 1'b1, acc, cons);
      if (acc) begin
        d = tdt[idx][OW-1:0];
        exp_q.push_back({tov[idx][0], d});
        idx++;
      end
      if (cons) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL sat_extra got=%0d want=none", out_data); end
        else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_data} !== e) begin
            bad++; $display("FAIL sat_data beat=%0d got=%0d/%0d want=%0d/%0d", n_out, out_data, out_ovf, e[OW-1:0], e[OW]);
          end
        end
        $display("beat sat data=%0d ovf=%0d", out_data, out_ovf);
      end
    end
    total++;
    if (n_out != 8) begin bad++; $display("FAIL sat_count got=%0d want=8", n_out); end
  endtask

  task automatic test_backpressure();
    logic [OW:0] e;
    logic [OW-1:0] prev_data;
    logic prev_stall, ordy, acc, cons;
    int k, n_out, first;
    k = 1;
    n_out = 0;
    first = -1;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
      @(negedge clk);
      if (out_valid && first < 0) first = cyc;
      ordy = !(first >= 0 && cyc - first >= 3 && cyc - first <= 5);
      in_valid  = (k <= 8);
      a_data    = pa(2 * k, 0, 0);
      b_coef    = pb(64, 0, 0);
      offset    = '0;
      out_ready = ordy;
      #1;
      total++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, out_ready | ~out_valid);
      end
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          bad++; $display("FAIL bp_hold cyc=%0d got=%0d/%b want=%0d/1", cyc, out_data, out_valid, prev_data);
        end
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (acc) begin
        exp_q.push_back({1'b0, 16'(k)});
        k++;
      end
      if (cons) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra got=%0d want=none", out_data); end
        else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_data} !== e) begin
            bad++; $display("FAIL bp_data got=%0d/%0d want=%0d/%0d", out_data, out_ovf, e[OW-1:0], e[OW]);
          end
        end
        $display("beat bp data=%0d ovf=%0d", out_data, out_ovf);
      end
    end
    total++;
    if (n_out != 8 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_count got=%0d left=%0d want=8/0", n_out, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc, cons;
    logic [OW:0] e;
    int seen, lat;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pa(100, 200, 300), pb(64, 32, 16), 0, 1'b0, acc, cons);
    end
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      step(1'b0, '0, '0, 0, 1'b0, acc, cons);
      if (out_valid) seen = 1;
    end
    total++;
    if (seen == 0 || out_data !== 16'd138) begin
      bad++; $display("FAIL rm_pre got=%0d/%b want=138/1", out_data, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_async_valid got=%b want=0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL rm_async_data got=%0d want=0", out_data); end
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL rm_async_ovf got=%b want=0", out_ovf); end
    exp_q.delete();
    #9 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, '0, '0, 0, 1'b1, acc, cons);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_ghost cyc=%0d got=%b want=0", c, out_valid); end
    end
    step(1'b1, pa(1000, 0, 0), pb(-128, 0, 0), 17'sd2000, 1'b1, acc, cons);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL rm_accept got=%b want=1", acc); end
    if (acc) exp_q.push_back({1'b0, 16'd1000});
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      step(1'b0, '0, '0, 0, 1'b1, acc, cons);
      if (cons) begin
        lat = c;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rm_extra got=%0d want=none", out_data); end
        else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_data} !== e) begin
            bad++; $display("FAIL rm_data got=%0d/%0d want=%0d/%0d", out_data, out_ovf, e[OW-1:0], e[OW]);
          end
        end
        $display("beat rm data=%0d ovf=%0d", out_data, out_ovf);
      end
    end
    total++;
    if (lat != 4) begin bad++; $display("FAIL rm_latency got=%0d want=4", lat); end
  endtask

  task automatic test_full_rate();
    logic acc, cons, v;
    logic [NCH*AW-1:0] a;
    logic [NCH*BW-1:0] b;
    logic signed [FW-1:0] o;
    logic [OW:0] e;
    int n_in, n_out;
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 80 && n_out < 64; c++) begin
      v = (n_in < 64);
      for (int i = 0; i < NCH; i++) begin
        a[i*AW +: AW] = AW'($urandom_range(0, 65535) >> $urandom_range(0, 10));
        b[i*BW +: BW] = BW'($urandom_range(0, 255));
      end
      o = FW'($urandom_range(0, 4000)) - FW'(2000);
      step(v, a, b, o, 1'b1, acc, cons);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL fr_in_ready cyc=%0d got=%b want=1", c, in_ready); end
      if (acc) begin
        exp_q.push_back(model(a, b, o));
        n_in++;
      end
      total++;
      if (cons !== (c >= 4 && c < 68)) begin
        bad++; $display("FAIL fr_rate cyc=%0d got=%b want=%b", c, cons, (c >= 4 && c < 68));
      end
      if (cons) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL fr_extra got=%0d want=none", out_data); end
        else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_data} !== e) begin
            bad++; $display("FAIL fr_data beat=%0d got=%0d/%0d want=%0d/%0d", n_out, out_data, out_ovf, e[OW-1:0], e[OW]);
          end
        end
        $display("beat fr data=%0d ovf=%0d", out_data, out_ovf);
      end
    end
    total++;
    if (n_out != 64) begin bad++; $display("FAIL fr_count got=%0d want=64", n_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_full_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
